analyzer_capture_ctrl: RTL and testbench

Parametrised capture controller for the logic capture peripheral. It sequences a capture through pre-trigger fill, armed (circular) sampling and post-trigger counting, and generates sample-buffer write strobes and addresses. It records the trigger address and delays aborts to a page boundary so the buffer never holds a partial page. It sits between the register interface (start/abort/counts), the trigger unit (trig_hit) and the sample RAM.

---
 rtl/analyzer_pkg.sv | 15 +
 rtl/analyzer_sample_counter.sv | 37 +++
 rtl/analyzer_capture_ctrl.sv | 169 ++++++++++++++++
 tb/tb_analyzer_capture_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/analyzer_pkg.sv
// Shared types and default sizing for the logic-analyzer capture controller.
package analyzer_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_PAGE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ARMED,
    ST_POST,
    ST_ABORT
  } state_t;

endpackage

// File: rtl/analyzer_sample_counter.sv
// Loadable down-counter with zero and last-count flags; used for the pre- and post-trigger sample counts.
module analyzer_sample_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && !zero) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
  // "last" marks that the next decrement brings the counter to zero.
  assign last = (count_q == W'(1));

endmodule

// File: rtl/analyzer_capture_ctrl.sv
// Capture sequencer: pre-trigger fill, circular armed sampling, post-trigger count, page-aligned abort.
// Build option: ANALYZER_CTRL_REARM_EN restarts a capture on completion while start stays high.
module analyzer_capture_ctrl
  import analyzer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PAGE_W = DEF_PAGE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              sample_valid,
  input  logic              trig_hit,
  input  logic [ADDR_W-1:0] pre_count,
  input  logic [ADDR_W-1:0] post_count,
  output logic              idle,
  output logic              pre_trigger,
  output logic              post_trigger,
  output logic              aborting,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              trig_valid,
  output logic              done,
  output logic              aborted
);

  state_t            state_q, state_d;
  logic              start_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              trig_valid_q, trig_valid_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic pre_load, pre_dec, pre_zero, pre_last;
  logic post_load, post_dec, post_zero, post_last;
  logic complete, start_rise, page_start, page_end;

  assign start_rise = start & ~start_q;
  assign page_start = (addr_q[PAGE_W-1:0] == '0);
  assign page_end   = &addr_q[PAGE_W-1:0];
  assign wr_en      = sample_valid && (state_q != ST_IDLE);
  assign pre_dec    = wr_en && (state_q == ST_FILL);
  assign post_dec   = wr_en && (state_q == ST_POST);

  analyzer_sample_counter #(.W(ADDR_W)) u_pre_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (pre_load),
    .load_val (pre_count),
    .dec      (pre_dec),
    .zero     (pre_zero),
    .last     (pre_last)
  );

  analyzer_sample_counter #(.W(ADDR_W)) u_post_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (post_load),
    .load_val (post_count),
    .dec      (post_dec),
    .zero     (post_zero),
    .last     (post_last)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    trig_addr_d  = trig_addr_q;
    trig_valid_d = trig_valid_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    pre_load     = 1'b0;
    post_load    = 1'b0;
    complete     = 1'b0;
    if (wr_en) begin
      addr_d = addr_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_rise && !abort) begin
          pre_load     = 1'b1;
          addr_d       = '0;
          trig_valid_d = 1'b0;
          state_d      = (pre_count == '0) ? ST_ARMED : ST_FILL;
        end
      end
      ST_FILL, ST_ARMED, ST_POST: begin
        if (abort) begin
          // Only stop at once if the buffer already ends on a whole page.
          if (page_start && !wr_en) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
          end else begin
            state_d = ST_ABORT;
          end
        end else if (state_q == ST_FILL) begin
          if (pre_zero || (wr_en && pre_last)) begin
            state_d = ST_ARMED;
          end
        end else if (state_q == ST_ARMED) begin
          if (trig_hit && sample_valid) begin
            trig_addr_d  = addr_q;
            trig_valid_d = 1'b1;
            post_load    = 1'b1;
            if (post_count == '0) begin
              complete = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end
        end else if (post_zero || (wr_en && post_last)) begin
          complete = 1'b1;
        end
      end
      ST_ABORT: begin
        if (wr_en && page_end) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (complete) begin
      done_d  = 1'b1;
      state_d = ST_IDLE;
`ifdef ANALYZER_CTRL_REARM_EN
      if (start) begin
        pre_load     = 1'b1;
        trig_valid_d = 1'b0;
        state_d      = (pre_count == '0) ? ST_ARMED : ST_FILL;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      addr_q       <= '0;
      trig_addr_q  <= '0;
      trig_valid_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      addr_q       <= addr_d;
      trig_addr_q  <= trig_addr_d;
      trig_valid_q <= trig_valid_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign idle         = (state_q == ST_IDLE);
  assign pre_trigger  = (state_q == ST_FILL) || (state_q == ST_ARMED);
  assign post_trigger = (state_q == ST_POST);
  assign aborting     = (state_q == ST_ABORT);
  assign wr_addr      = addr_q;
  assign trig_addr    = trig_addr_q;
  assign trig_valid   = trig_valid_q;
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule

// File: tb/tb_analyzer_capture_ctrl.sv
// Scoreboard bench for analyzer_capture_ctrl (ADDR_W=6, PAGE_W=3); honours ANALYZER_CTRL_REARM_EN.
module tb_analyzer_capture_ctrl;

  localparam int AW = 6;
  localparam int EV_WR = 0, EV_DONE = 1, EV_ABORT = 2;

  typedef struct {
    int kind;
    int addr;
  } evt_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, abort = 1'b0, sample_valid = 1'b0, trig_hit = 1'b0;
  logic [AW-1:0] pre_count = '0, post_count = '0;
  logic          idle, pre_trigger, post_trigger, aborting, wr_en, trig_valid, done, aborted;
  logic [AW-1:0] wr_addr, trig_addr;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  analyzer_capture_ctrl #(.ADDR_W(AW), .PAGE_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .sample_valid (sample_valid),
    .trig_hit     (trig_hit),
    .pre_count    (pre_count),
    .post_count   (post_count),
    .idle         (idle),
    .pre_trigger  (pre_trigger),
    .post_trigger (post_trigger),
    .aborting     (aborting),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .trig_addr    (trig_addr),
    .trig_valid   (trig_valid),
    .done         (done),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic push(input int kind, input int addr);
    evt_t e;
    e.kind = kind;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic push_wr_range(input int first, input int last);
    for (int a = first; a <= last; a++) push(EV_WR, a % 64);
  endtask

  task automatic observe(input int kind, input int addr);
    evt_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_evt: got kind %0d addr %0d, expected none", kind, addr);
    end else begin
      e = exp_q.pop_front();
      check("evt_kind", kind, e.kind);
      if (kind == EV_WR && e.kind == EV_WR) check("wr_addr", addr, e.addr);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (done)    observe(EV_DONE, 0);
      if (aborted) observe(EV_ABORT, 0);
      if (wr_en)   observe(EV_WR, int'(wr_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_capture(input int pre, input int post);
    pre_count  = AW'(pre);
    post_count = AW'(post);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    reset = 1'b0;
    tick();
    check("rst_idle", idle, 1);
    check("rst_flags", {pre_trigger, post_trigger, aborting}, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_trig_valid", trig_valid, 0);
    check("rst_trig_addr", trig_addr, 0);

    // Normal capture: trigger at sample 2 ignored (FILL), taken at sample 6.
    push_wr_range(0, 10);
    push(EV_DONE, 0);
    begin_capture(4, 5);
    sample_valid = 1'b1;
    for (int s = 1; s <= 11; s++) begin
      trig_hit = (s == 2 || s == 6);
      tick();
      if (s == 1) check("fill_pre_trigger", pre_trigger, 1);
      if (s == 6) check("post_state", post_trigger, 1);
    end
    sample_valid = 1'b0;
    trig_hit = 1'b0;
    check("norm_done", done, 1);
    check("norm_trig_addr", trig_addr, 5);
    check("norm_trig_valid", trig_valid, 1);
    tick();
    check("norm_done_pulse", done, 0);

    // Abort at wr_addr 3 in ARMED: finish the page through address 7.
    push_wr_range(0, 7);
    push(EV_ABORT, 0);
    begin_capture(0, 5);
    sample_valid = 1'b1;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_state", aborting, 1);
    repeat (4) tick();
    sample_valid = 1'b0;
    check("abort_idle", idle, 1);
    check("abort_trig_valid", trig_valid, 0);
    tick();

    // Abort and trigger together at page boundary with no write: immediate stop.
    push_wr_range(0, 7);
    push(EV_ABORT, 0);
    begin_capture(0, 5);
    sample_valid = 1'b1;
    repeat (8) tick();
    sample_valid = 1'b0;
    abort = 1'b1;
    trig_hit = 1'b1;
    tick();
    abort = 1'b0;
    trig_hit = 1'b0;
    check("pgabort_idle", idle, 1);
    check("pgabort_aborted", aborted, 1);
    check("pgabort_trig_valid", trig_valid, 0);
    tick();

    // Address wrap past 63, then a trigger with post_count 0.
    push_wr_range(0, 64);
    push(EV_DONE, 0);
    begin_capture(62, 0);
    sample_valid = 1'b1;
    for (int s = 0; s <= 64; s++) begin
      trig_hit = (s == 64);
      tick();
    end
    sample_valid = 1'b0;
    trig_hit = 1'b0;
    check("wrap_trig_addr", trig_addr, 0);
    check("wrap_wr_addr", wr_addr, 1);
    check("wrap_idle", idle, 1);
    tick();

    // Start held high: back-to-back captures only with rearm enabled.
    push_wr_range(0, 2);
    push(EV_DONE, 0);
`ifdef ANALYZER_CTRL_REARM_EN
    push_wr_range(3, 5);
    push(EV_DONE, 0);
`endif
    pre_count = AW'(1);
    post_count = AW'(1);
    start = 1'b1;
    tick();
    sample_valid = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      trig_hit = (c == 1 || c == 4);
      if (c == 5) start = 1'b0;
      tick();
    end
    sample_valid = 1'b0;
    trig_hit = 1'b0;
    tick();
`ifdef ANALYZER_CTRL_REARM_EN
    check("rearm_wr_addr", wr_addr, 6);
    check("rearm_trig_addr", trig_addr, 4);
`else
    check("single_wr_addr", wr_addr, 3);
    check("single_trig_addr", trig_addr, 1);
`endif
    check("rearm_idle", idle, 1);

    // Reset mid-POST: idle immediately, no done pulse afterwards.
    push_wr_range(0, 2);
    begin_capture(0, 10);
    sample_valid = 1'b1;
    trig_hit = 1'b1;
    tick();
    trig_hit = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check("arst_idle", idle, 1);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_trig_valid", trig_valid, 0);
    check("arst_wr_en", wr_en, 0);
    sample_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("arst_done", done, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
